// File: rtl/fetch_prefetch_stage.sv
// Pipelined OBI instruction fetcher with a prefetch FIFO feeding the decode pipeline register.
// Redirects flush the FIFO and drop every response still in flight.
module fetch_prefetch_stage #(
    parameter int unsigned     XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_ADDR      = {XLEN{1'b0}},
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            squash_i,
    input  logic            stall_i,
    input  logic            target_sel_i,
    input  logic [XLEN-1:0] target_addr_i,
    output logic            imem_req_o,
    input  logic            imem_gnt_i,
    output logic [XLEN-1:0] imem_addr_o,
    output logic            imem_we_o,
    output logic [3:0]      imem_be_o,
    output logic [31:0]     imem_wdata_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            fifo_empty_o,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] next_pc_o
);

    localparam int unsigned     AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CW         = AW + 1;
    localparam logic [CW:0]     DEPTH_C    = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   FULL_C     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   MAX_C      = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]   ZERO_C     = {CW{1'b0}};
    localparam logic [CW-1:0]   ONE_C      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   PTR_ONE_C  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] STEP_C     = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] ALIGN_C    = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0]  fetch_pc_r, saved_target_r, resp_pc_r;
    logic [CW-1:0]    outstanding_r, discard_r, count_r;
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic             pending_r, redirect_pend_r;
    logic [XLEN+31:0] fifo_mem_r [FIFO_DEPTH];
    logic             valid_r;
    logic [31:0]      instr_r;
    logic [XLEN-1:0]  pc_r, next_pc_r;

    logic             credit_s, req_s, grant_s, resp_s, push_s, pop_s, hold_target_s;
    logic [XLEN-1:0]  target_s;
    logic [CW-1:0]    outstanding_nx_s, discard_nx_s, count_nx_s;
    logic [XLEN+31:0] head_s;

    assign target_s      = target_addr_i & ALIGN_C;
    assign credit_s      = (({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C) &&
                           (outstanding_r < MAX_C);
    assign grant_s       = req_s & imem_gnt_i;
    assign resp_s        = imem_rvalid_i & (outstanding_r != ZERO_C);
    assign push_s        = resp_s & ~target_sel_i & (discard_r == ZERO_C);
    assign pop_s         = ~target_sel_i & ~squash_i & ~stall_i & (count_r != ZERO_C);
    assign hold_target_s = target_sel_i & pending_r & ~imem_gnt_i;
    assign head_s        = fifo_mem_r[rd_ptr_r];

    // Request: a held request always stays up; a new one needs credit and no redirect this cycle.
    always_comb begin
        req_s = 1'b0;
        if (!rst_ni) begin
            req_s = 1'b0;
        end else if (pending_r) begin
            req_s = 1'b1;
        end else if (!target_sel_i && credit_s) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Next outstanding, discard and FIFO occupancy counts.
    always_comb begin
        outstanding_nx_s = outstanding_r;
        discard_nx_s     = discard_r;
        count_nx_s       = count_r;
        if (grant_s && !resp_s) begin
            outstanding_nx_s = outstanding_r + ONE_C;
        end else if (!grant_s && resp_s) begin
            outstanding_nx_s = outstanding_r - ONE_C;
        end else begin
            outstanding_nx_s = outstanding_r;
        end
        // A held request granted after a redirect belongs to the old stream.
        if (target_sel_i) begin
            discard_nx_s = outstanding_nx_s;
        end else if (resp_s && (discard_r != ZERO_C) && !(grant_s && redirect_pend_r)) begin
            discard_nx_s = discard_r - ONE_C;
        end else if (!(resp_s && (discard_r != ZERO_C)) && grant_s && redirect_pend_r) begin
            discard_nx_s = discard_r + ONE_C;
        end else begin
            discard_nx_s = discard_r;
        end
        if (target_sel_i) begin
            count_nx_s = ZERO_C;
        end else if (push_s && !pop_s) begin
            count_nx_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_nx_s = count_r - ONE_C;
        end else begin
            count_nx_s = count_r;
        end
    end

    // Fetch address, OBI hold tracking and in-flight bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_r      <= RESET_ADDR;
            saved_target_r  <= {XLEN{1'b0}};
            redirect_pend_r <= 1'b0;
            pending_r       <= 1'b0;
            outstanding_r   <= ZERO_C;
            discard_r       <= ZERO_C;
        end else begin
            pending_r     <= req_s & ~imem_gnt_i;
            outstanding_r <= outstanding_nx_s;
            discard_r     <= discard_nx_s;
            if (target_sel_i) begin
                if (hold_target_s) begin
                    saved_target_r  <= target_s;
                    redirect_pend_r <= 1'b1;
                end else begin
                    fetch_pc_r      <= target_s;
                    redirect_pend_r <= 1'b0;
                end
            end else if (grant_s) begin
                fetch_pc_r      <= redirect_pend_r ? saved_target_r : fetch_pc_r + STEP_C;
                redirect_pend_r <= 1'b0;
            end
        end
    end

    // FIFO pointers and the PC of the next accepted response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= ZERO_C;
            resp_pc_r <= RESET_ADDR;
        end else begin
            count_r <= count_nx_s;
            if (target_sel_i) begin
                wr_ptr_r  <= {AW{1'b0}};
                rd_ptr_r  <= {AW{1'b0}};
                resp_pc_r <= target_s;
            end else begin
                if (push_s) begin
                    wr_ptr_r  <= wr_ptr_r + PTR_ONE_C;
                    resp_pc_r <= resp_pc_r + STEP_C;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end
            end
        end
    end

    // FIFO storage of {pc, instruction}.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {resp_pc_r, imem_rdata_i};
        end
    end

    // Decode-facing pipeline register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r   <= 1'b0;
            instr_r   <= 32'h0000_0000;
            pc_r      <= {XLEN{1'b0}};
            next_pc_r <= {XLEN{1'b0}};
        end else if (target_sel_i || squash_i) begin
            valid_r <= 1'b0;
        end else if (stall_i) begin
            valid_r <= valid_r;
        end else if (pop_s) begin
            valid_r   <= 1'b1;
            instr_r   <= head_s[31:0];
            pc_r      <= head_s[XLEN+31:32];
            next_pc_r <= head_s[XLEN+31:32] + STEP_C;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign imem_req_o   = req_s;
    assign imem_addr_o  = fetch_pc_r;
    assign imem_we_o    = 1'b0;
    assign imem_be_o    = 4'b1111;
    assign imem_wdata_o = 32'h0000_0000;
    assign fifo_empty_o = (count_r == ZERO_C);
    assign valid_o      = valid_r;
    assign instr_o      = instr_r;
    assign pc_o         = pc_r;
    assign next_pc_o    = next_pc_r;

    fetch_prefetch_stage_chk u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .full   (count_r == FULL_C)
    );

endmodule

// Protocol checker: the credit scheme must never push into a full FIFO.
module fetch_prefetch_stage_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic push,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Scoreboard bench: an imem model records grants/responses and a reference queue
// predicts the instruction stream, the OBI request behaviour and the output register.
module tb_fetch_prefetch_stage;

    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            squash_i = 1'b0, stall_i = 1'b0, target_sel_i = 1'b0;
    logic [XLEN-1:0] target_addr_i = '0;
    logic            imem_req_o, imem_gnt_i = 1'b0, imem_we_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [3:0]      imem_be_o;
    logic [31:0]     imem_wdata_o;
    logic            imem_rvalid_i = 1'b0;
    logic [31:0]     imem_rdata_i = '0;
    logic            fifo_empty_o, valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o, next_pc_o;

    always #5 clk_i = ~clk_i;

    fetch_prefetch_stage #(
        .XLEN(XLEN), .RESET_ADDR(64'h0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .squash_i(squash_i), .stall_i(stall_i),
        .target_sel_i(target_sel_i), .target_addr_i(target_addr_i),
        .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i), .imem_addr_o(imem_addr_o),
        .imem_we_o(imem_we_o), .imem_be_o(imem_be_o), .imem_wdata_o(imem_wdata_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .fifo_empty_o(fifo_empty_o), .valid_o(valid_o), .instr_o(instr_o),
        .pc_o(pc_o), .next_pc_o(next_pc_o)
    );

    typedef struct packed { logic [63:0] addr; logic stale; } infl_t;
    typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ent_t;

    infl_t       infl_q[$];
    ent_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_fetch, prev_addr;
    logic        held_stale, prev_pend;
    logic        out_v;
    logic [31:0] out_instr;
    logic [63:0] out_pc, out_npc;

    function automatic logic [31:0] rdata_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h3C5A_96E1;
    endfunction

    task automatic model_reset();
        infl_q.delete();
        exp_q.delete();
        exp_fetch = 64'h0; prev_addr = 64'h0;
        held_stale = 1'b0; prev_pend = 1'b0;
        out_v = 1'b0; out_instr = 32'h0; out_pc = 64'h0; out_npc = 64'h0;
    endtask

    // Called at a negedge; drives one cycle, predicts, checks, returns at the next negedge.
    task automatic step(input logic gnt_v, input logic rsp_v, input logic stall_v,
                        input logic squash_v, input logic redir_v, input logic [63:0] tgt_v);
        logic        exp_req, do_rsp;
        logic [63:0] exp_addr;
        infl_t       r;
        ent_t        e;
        do_rsp        = rsp_v && (infl_q.size() > 0);
        imem_gnt_i    = gnt_v;
        stall_i       = stall_v;
        squash_i      = squash_v;
        target_sel_i  = redir_v;
        target_addr_i = tgt_v;
        imem_rvalid_i = do_rsp;
        imem_rdata_i  = do_rsp ? rdata_of(infl_q[0].addr) : 32'h0;
        #1;
        exp_req  = prev_pend || (!redir_v && (exp_q.size() + infl_q.size() < 4) && (infl_q.size() < 2));
        exp_addr = prev_pend ? prev_addr : exp_fetch;
        n_vec++;
        if (imem_req_o !== exp_req) begin
            n_err++;
            $display("FAIL imem_req: got %b expected %b at %0t", imem_req_o, exp_req, $time);
        end
        if (exp_req) begin
            n_vec++;
            if (imem_addr_o !== exp_addr) begin
                n_err++;
                $display("FAIL imem_addr: got %h expected %h at %0t", imem_addr_o, exp_addr, $time);
            end
        end
        if (redir_v || squash_v) out_v = 1'b0;
        else if (stall_v) out_v = out_v;
        else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            out_v = 1'b1; out_pc = e.pc; out_instr = e.instr; out_npc = e.pc + 64'd4;
        end else out_v = 1'b0;
        if (do_rsp) begin
            r = infl_q.pop_front();
            if (!r.stale && !redir_v) exp_q.push_back({r.addr, rdata_of(r.addr)});
        end
        if (exp_req && gnt_v) begin
            infl_q.push_back({exp_addr, redir_v || held_stale});
            if (redir_v || held_stale) held_stale = 1'b0;
            else exp_fetch = exp_fetch + 64'd4;
        end
        if (redir_v) begin
            exp_q.delete();
            foreach (infl_q[i]) infl_q[i].stale = 1'b1;
            exp_fetch = tgt_v & ~64'd3;
            if (exp_req && !gnt_v) held_stale = 1'b1;
        end
        prev_pend = exp_req && !gnt_v;
        prev_addr = exp_addr;
        @(posedge clk_i);
        #1;
        n_vec++;
        if ({valid_o, instr_o, pc_o, next_pc_o} !== {out_v, out_instr, out_pc, out_npc}) begin
            n_err++;
            $display("FAIL out_reg: got v=%b i=%h pc=%h npc=%h expected v=%b i=%h pc=%h npc=%h at %0t",
                     valid_o, instr_o, pc_o, next_pc_o, out_v, out_instr, out_pc, out_npc, $time);
        end
        n_vec++;
        if (fifo_empty_o !== (exp_q.size() == 0)) begin
            n_err++;
            $display("FAIL fifo_empty: got %b expected %b at %0t", fifo_empty_o, exp_q.size() == 0, $time);
        end
        @(negedge clk_i);
    endtask

    // Asserts reset between edges, checks outputs immediately, releases at the following negedge.
    task automatic do_reset();
        #3 rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({imem_req_o, valid_o, instr_o, pc_o, next_pc_o, fifo_empty_o} !== {1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b v=%b i=%h pc=%h npc=%h empty=%b expected all zero, empty=1",
                     imem_req_o, valid_o, instr_o, pc_o, next_pc_o, fifo_empty_o);
        end
        model_reset();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; stall_i = 1'b0; squash_i = 1'b0; target_sel_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        do_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        n_vec++;
        if ({imem_req_o, fifo_empty_o} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_full: got req=%b empty=%b expected req=0 empty=0", imem_req_o, fifo_empty_o);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_redirect();
        bit seen = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1000);
        for (int i = 0; i < 12 && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
            if (valid_o === 1'b1) begin
                seen = 1'b1;
                n_vec++;
                if (pc_o !== 64'h1000) begin
                    n_err++;
                    $display("FAIL redirect_first_pc: got %h expected %h", pc_o, 64'h1000);
                end
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL redirect_timeout: valid_o got 0 expected 1 within 12 cycles");
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_gnt_hold();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h2003);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_squash_stall();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, {$urandom, $urandom});
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_gnt_hold();
        test_squash_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
